// File: rtl/aggr_scheduler_if.sv
// ---------------------------------------------------------------------------
// aggr_scheduler_if
//   Bundles the control, FIFO, Wh-BRAM and issue signals of the GAT aggregation
//   scheduler. clk and rst stay plain ports on the scheduler itself.
//
//   master : scheduler side (drives pops, BRAM address, issue markers, status)
//   slave  : environment side (start/config, FIFO status, producer writes)
//
//   Signals
//     start, num_subgraphs_i      layer start pulse and subgraph count
//     nn_ff_dout/_empty/_rd_vld   node-count descriptor FIFO
//     alpha_ff_empty/_rd_vld      alpha FIFO
//     wh_wr_vld                   Wh producer commit strobe
//     wh_bram_addrb               Wh BRAM read address
//     wh_space_o                  free Wh entries
//     aggr_rdy_i                  feature controller ready for a new subgraph
//     issue_vld/first/last_o      beat strobe and subgraph markers
//     busy_o, done_o, wh_ovf_o    status
//     stall_cycles_o              performance counter
// ---------------------------------------------------------------------------
interface aggr_scheduler_if #(
    parameter int NUM_SUBGRAPHS = 2708,
    parameter int MAX_NODES     = 168,
    parameter int WH_DEPTH      = 256
);
    localparam int NUM_SG_W       = $clog2(NUM_SUBGRAPHS + 1);
    localparam int NUM_NODE_WIDTH = $clog2(MAX_NODES);
    localparam int WH_ADDR_W      = $clog2(WH_DEPTH);
    localparam int CRED_W         = $clog2(WH_DEPTH + 1);

    logic                      start;
    logic [NUM_SG_W-1:0]       num_subgraphs_i;
    logic [NUM_NODE_WIDTH-1:0] nn_ff_dout;
    logic                      nn_ff_empty;
    logic                      nn_ff_rd_vld;
    logic                      alpha_ff_empty;
    logic                      alpha_ff_rd_vld;
    logic                      wh_wr_vld;
    logic [WH_ADDR_W-1:0]      wh_bram_addrb;
    logic [CRED_W-1:0]         wh_space_o;
    logic                      aggr_rdy_i;
    logic                      issue_vld_o;
    logic                      issue_first_o;
    logic                      issue_last_o;
    logic                      busy_o;
    logic                      done_o;
    logic                      wh_ovf_o;
    logic [31:0]               stall_cycles_o;

    modport master (
        input  start, num_subgraphs_i, nn_ff_dout, nn_ff_empty, alpha_ff_empty,
               wh_wr_vld, aggr_rdy_i,
        output nn_ff_rd_vld, alpha_ff_rd_vld, wh_bram_addrb, wh_space_o,
               issue_vld_o, issue_first_o, issue_last_o, busy_o, done_o,
               wh_ovf_o, stall_cycles_o
    );

    modport slave (
        output start, num_subgraphs_i, nn_ff_dout, nn_ff_empty, alpha_ff_empty,
               wh_wr_vld, aggr_rdy_i,
        input  nn_ff_rd_vld, alpha_ff_rd_vld, wh_bram_addrb, wh_space_o,
               issue_vld_o, issue_first_o, issue_last_o, busy_o, done_o,
               wh_ovf_o, stall_cycles_o
    );
endinterface

// File: rtl/aggr_scheduler.sv
// ---------------------------------------------------------------------------
// aggr_scheduler
//   Sequences the aggregation datapath of one GAT layer. For each subgraph it
//   pops a node-count descriptor, then issues one Wh-BRAM read and one alpha
//   pop per node in lockstep, tagging each beat with first/last markers for
//   the MAC stage. Wh-buffer occupancy is tracked as credits against the Wh
//   producer; issue waits for a credit and a non-empty alpha FIFO. New
//   subgraphs only begin when the feature controller is ready.
//
//   Ports
//     clk   single clock
//     rst   synchronous, active-high reset
//     bus   aggr_scheduler_if.master (see the interface file for the list)
//
//   Optional feature (macro AGGR_SCHED_PERF_EN)
//     defined   : stall_cycles_o counts RUN cycles without an issue,
//                 saturating, cleared on an accepted start
//     undefined : stall_cycles_o is tied to 0
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | waiting for start
//   FETCH | waiting for a descriptor and aggr_rdy_i, then pop it
//   RUN   | issuing one beat per node of the current subgraph
//   DONE  | one-cycle layer-complete pulse
// ---------------------------------------------------------------------------
module aggr_scheduler #(
    parameter int NUM_SUBGRAPHS = 2708,
    parameter int MAX_NODES     = 168,
    parameter int WH_DEPTH      = 256
) (
    input  logic             clk,
    input  logic             rst,
    aggr_scheduler_if.master bus
);
    localparam int NUM_SG_W       = $clog2(NUM_SUBGRAPHS + 1);
    localparam int NUM_NODE_WIDTH = $clog2(MAX_NODES);
    localparam int WH_ADDR_W      = $clog2(WH_DEPTH);
    localparam int CRED_W         = $clog2(WH_DEPTH + 1);

    localparam logic [WH_ADDR_W-1:0] PTR_MAX = WH_ADDR_W'(WH_DEPTH - 1);
    localparam logic [CRED_W-1:0]    WH_FULL = CRED_W'(WH_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [NUM_SG_W-1:0]       num_sg_q;
    logic [NUM_SG_W-1:0]       sg_cnt_q;
    logic [NUM_NODE_WIDTH-1:0] node_tot_q;
    logic [NUM_NODE_WIDTH-1:0] node_cnt_q;
    logic [WH_ADDR_W-1:0]      rd_ptr_q;
    logic [CRED_W-1:0]         wh_avail_q;
    logic                      wh_ovf_q;
    logic                      issue_vld_q;
    logic                      issue_first_q;
    logic                      issue_last_q;

    logic                      start_acc;
    logic                      pop;
    logic                      issue;
    logic                      sg_adv;
    logic                      last_beat;
    logic                      sg_last;
    logic [NUM_SG_W-1:0]       sg_cnt_inc;
    logic [NUM_NODE_WIDTH-1:0] node_last_idx;

    assign sg_cnt_inc    = sg_cnt_q + 1'b1;
    assign sg_last       = (sg_cnt_inc == num_sg_q);
    // Only evaluated in RUN, where node_tot_q is at least 1.
    assign node_last_idx = node_tot_q - 1'b1;
    assign last_beat     = (node_cnt_q == node_last_idx);

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and control strobes
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        start_acc = 1'b0;
        pop       = 1'b0;
        issue     = 1'b0;
        sg_adv    = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    start_acc = 1'b1;
                    state_d   = (bus.num_subgraphs_i == '0) ? DONE : FETCH;
                end
            end

            FETCH: begin
                if (!bus.nn_ff_empty && bus.aggr_rdy_i) begin
                    pop = 1'b1;
                    // An empty subgraph is consumed here without issuing.
                    if (bus.nn_ff_dout == '0) begin
                        sg_adv  = 1'b1;
                        state_d = sg_last ? DONE : FETCH;
                    end else begin
                        state_d = RUN;
                    end
                end
            end

            RUN: begin
                if (!bus.alpha_ff_empty && (wh_avail_q != '0)) begin
                    issue = 1'b1;
                    if (last_beat) begin
                        sg_adv  = 1'b1;
                        state_d = sg_last ? DONE : FETCH;
                    end
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Layer / subgraph bookkeeping and read pointer
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            num_sg_q   <= '0;
            sg_cnt_q   <= '0;
            node_tot_q <= '0;
            node_cnt_q <= '0;
            rd_ptr_q   <= '0;
        end else begin
            if (start_acc) begin
                num_sg_q <= bus.num_subgraphs_i;
                sg_cnt_q <= '0;
                rd_ptr_q <= '0;
            end
            if (pop) begin
                node_tot_q <= bus.nn_ff_dout;
                node_cnt_q <= '0;
            end
            if (sg_adv) begin
                sg_cnt_q <= sg_cnt_inc;
            end
            if (issue) begin
                rd_ptr_q   <= (rd_ptr_q == PTR_MAX) ? '0 : rd_ptr_q + 1'b1;
                node_cnt_q <= node_cnt_q + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Issue markers: registered so they line up with the 1-cycle BRAM and
    // FIFO read data of the beat issued in the previous cycle.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            issue_vld_q   <= 1'b0;
            issue_first_q <= 1'b0;
            issue_last_q  <= 1'b0;
        end else begin
            issue_vld_q   <= issue;
            issue_first_q <= issue && (node_cnt_q == '0);
            issue_last_q  <= issue && last_beat;
        end
    end

    // ------------------------------------------------------------------
    // Wh credits. Not cleared on start so the producer may run ahead of the
    // layer. A write into a full buffer is dropped and flagged; a set in the
    // same cycle as an accepted start wins over the clear.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            wh_avail_q <= '0;
            wh_ovf_q   <= 1'b0;
        end else begin
            if (start_acc) begin
                wh_ovf_q <= 1'b0;
            end
            if (bus.wh_wr_vld && !issue) begin
                if (wh_avail_q == WH_FULL) begin
                    wh_ovf_q <= 1'b1;
                end else begin
                    wh_avail_q <= wh_avail_q + 1'b1;
                end
            end else if (issue && !bus.wh_wr_vld) begin
                wh_avail_q <= wh_avail_q - 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stall performance counter
    // ------------------------------------------------------------------
`ifdef AGGR_SCHED_PERF_EN
    logic [31:0] stall_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
        end else if (start_acc) begin
            stall_q <= '0;
        end else if ((state_q == RUN) && !issue && (stall_q != '1)) begin
            stall_q <= stall_q + 1'b1;
        end
    end

    assign bus.stall_cycles_o = stall_q;
`else
    assign bus.stall_cycles_o = '0;
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.nn_ff_rd_vld    = pop;
    assign bus.alpha_ff_rd_vld = issue;
    assign bus.wh_bram_addrb   = rd_ptr_q;
    assign bus.wh_space_o      = WH_FULL - wh_avail_q;
    assign bus.issue_vld_o     = issue_vld_q;
    assign bus.issue_first_o   = issue_first_q;
    assign bus.issue_last_o    = issue_last_q;
    assign bus.busy_o          = (state_q != IDLE);
    assign bus.done_o          = (state_q == DONE);
    assign bus.wh_ovf_o        = wh_ovf_q;

endmodule

// File: tb/tb_aggr_scheduler.sv
// ---------------------------------------------------------------------------
// tb_aggr_scheduler
//   Directed bench for aggr_scheduler. A beat scoreboard (expected address and
//   first/last per beat, built from the descriptor list and a wrapping read
//   pointer) and a credit count are checked every cycle; directed cycle
//   tables pin timing, overflow, reset and stall behaviour.
// ---------------------------------------------------------------------------
module tb_aggr_scheduler;
    localparam int NUM_SUBGRAPHS = 2708;
    localparam int MAX_NODES     = 168;
    localparam int WH_DEPTH      = 256;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    aggr_scheduler_if #(
        .NUM_SUBGRAPHS(NUM_SUBGRAPHS),
        .MAX_NODES    (MAX_NODES),
        .WH_DEPTH     (WH_DEPTH)
    ) bus ();

    aggr_scheduler #(
        .NUM_SUBGRAPHS(NUM_SUBGRAPHS),
        .MAX_NODES    (MAX_NODES),
        .WH_DEPTH     (WH_DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // ---------------- FIFO environment ----------------
    int nn_q[$];
    int alpha_cnt   = 0;
    bit nn_pop_p    = 1'b0;
    bit alpha_pop_p = 1'b0;

    task automatic drive_fifos();
        bus.nn_ff_empty    = (nn_q.size() == 0);
        bus.nn_ff_dout     = (nn_q.size() > 0) ? 8'(nn_q[0]) : 8'd0;
        bus.alpha_ff_empty = (alpha_cnt == 0);
    endtask

    always @(posedge clk) begin
        #1;
        if (nn_pop_p && nn_q.size() > 0) void'(nn_q.pop_front());
        if (alpha_pop_p && alpha_cnt > 0) alpha_cnt--;
        drive_fifos();
    end

    // ---------------- model ----------------
    typedef struct {
        int addr;
        bit first;
        bit last;
    } beat_t;

    beat_t exp_q[$];
    int    addr_log[$];
    int    m_ptr   = 0;
    int    m_avail = 0;
    int    pend_addr = 0;

    task automatic expect_sub(input int n);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b.addr  = m_ptr;
            b.first = (i == 0);
            b.last  = (i == n - 1);
            exp_q.push_back(b);
            m_ptr = (m_ptr + 1) % WH_DEPTH;
        end
    endtask

    // ---------------- compare process ----------------
    always @(negedge clk) begin : mon
        beat_t e;
        nn_pop_p    = bus.nn_ff_rd_vld;
        alpha_pop_p = bus.alpha_ff_rd_vld;
        chk("wh_space", int'(bus.wh_space_o), WH_DEPTH - m_avail);
        if (rst) begin
            exp_q.delete();
            m_avail = 0;
        end else begin
            if (bus.issue_vld_o) begin
                if (exp_q.size() == 0) begin
                    chk("beat_unexpected", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat_addr",  pend_addr, e.addr);
                    chk("beat_first", int'(bus.issue_first_o), int'(e.first));
                    chk("beat_last",  int'(bus.issue_last_o),  int'(e.last));
                end
            end
            if (bus.alpha_ff_rd_vld) begin
                chk("issue_gate", int'(!bus.alpha_ff_empty && m_avail > 0), 1);
                pend_addr = int'(bus.wh_bram_addrb);
                addr_log.push_back(pend_addr);
            end
            if (bus.wh_wr_vld && !bus.alpha_ff_rd_vld) begin
                if (m_avail < WH_DEPTH) m_avail++;
            end else if (bus.alpha_ff_rd_vld && !bus.wh_wr_vld) begin
                m_avail--;
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        cyc();
        rst                 = 1'b1;
        bus.start           = 1'b0;
        bus.wh_wr_vld       = 1'b0;
        bus.aggr_rdy_i      = 1'b1;
        bus.num_subgraphs_i = '0;
        nn_q.delete();
        alpha_cnt = 0;
        drive_fifos();
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    task automatic give_credits(input int n);
        for (int i = 0; i < n; i++) begin
            cyc();
            bus.wh_wr_vld = 1'b1;
        end
        cyc();
        bus.wh_wr_vld = 1'b0;
    endtask

    // Directed tables for the {3,2} layer, index = cycles after start.
    int t2_alpha[10] = '{0, 0, 1, 1, 1, 0, 1, 1, 0, 0};
    int t2_addr [10] = '{0, 0, 0, 1, 2, 0, 3, 4, 0, 0};
    int t2_nnrd [10] = '{0, 1, 0, 0, 0, 1, 0, 0, 0, 0};
    int t2_done [10] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
    int t2_ivld [10] = '{0, 0, 0, 1, 1, 1, 0, 1, 1, 0};
    int t2_first[10] = '{0, 0, 0, 1, 0, 0, 0, 1, 0, 0};
    int t2_last [10] = '{0, 0, 0, 0, 0, 1, 0, 0, 1, 0};

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1);
    end

    initial begin
        bit seen;
        int sp[6];
        int n;

        bus.start           = 1'b0;
        bus.num_subgraphs_i = '0;
        bus.wh_wr_vld       = 1'b0;
        bus.aggr_rdy_i      = 1'b1;
        drive_fifos();

        // ---- reset state ----
        do_reset();
        @(negedge clk);
        chk("rst_busy",      int'(bus.busy_o), 0);
        chk("rst_done",      int'(bus.done_o), 0);
        chk("rst_issue_vld", int'(bus.issue_vld_o), 0);
        chk("rst_first",     int'(bus.issue_first_o), 0);
        chk("rst_last",      int'(bus.issue_last_o), 0);
        chk("rst_ovf",       int'(bus.wh_ovf_o), 0);
        chk("rst_addr",      int'(bus.wh_bram_addrb), 0);
        chk("rst_space",     int'(bus.wh_space_o), 256);
        chk("rst_stall",     int'(bus.stall_cycles_o), 0);
        chk("rst_nn_rd",     int'(bus.nn_ff_rd_vld), 0);
        chk("rst_alpha_rd",  int'(bus.alpha_ff_rd_vld), 0);

        // ---- two subgraphs {3,2}, 5 credits ----
        nn_q = '{3, 2};
        alpha_cnt = 5;
        drive_fifos();
        give_credits(5);
        @(negedge clk);
        chk("t2_space_pre", int'(bus.wh_space_o), 251);
        m_ptr = 0;
        expect_sub(3);
        expect_sub(2);
        for (int k = 0; k < 10; k++) begin
            cyc();
            bus.start = (k == 0);
            bus.num_subgraphs_i = 12'd2;
            @(negedge clk);
            chk($sformatf("t2_alpha_%0d", k), int'(bus.alpha_ff_rd_vld), t2_alpha[k]);
            if (t2_alpha[k] == 1)
                chk($sformatf("t2_addr_%0d", k), int'(bus.wh_bram_addrb), t2_addr[k]);
            chk($sformatf("t2_nnrd_%0d", k),  int'(bus.nn_ff_rd_vld), t2_nnrd[k]);
            chk($sformatf("t2_done_%0d", k),  int'(bus.done_o), t2_done[k]);
            chk($sformatf("t2_ivld_%0d", k),  int'(bus.issue_vld_o), t2_ivld[k]);
            chk($sformatf("t2_first_%0d", k), int'(bus.issue_first_o), t2_first[k]);
            chk($sformatf("t2_last_%0d", k),  int'(bus.issue_last_o), t2_last[k]);
        end
        chk("t2_space_end", int'(bus.wh_space_o), 256);
        chk("t2_busy_end",  int'(bus.busy_o), 0);
        chk("t2_beats_left", exp_q.size(), 0);

        // ---- wrap: {127,0,127,4}, producer writing every cycle ----
        do_reset();
        nn_q = '{127, 0, 127, 4};
        alpha_cnt = 258;
        drive_fifos();
        m_ptr = 0;
        expect_sub(127);
        expect_sub(0);
        expect_sub(127);
        expect_sub(4);
        addr_log.delete();
        cyc();
        bus.start = 1'b1;
        bus.num_subgraphs_i = 12'd4;
        bus.wh_wr_vld = 1'b1;
        cyc();
        bus.start = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 600 && !seen; k++) begin
            @(negedge clk);
            if (bus.done_o) seen = 1'b1;
            else cyc();
        end
        cyc();
        bus.wh_wr_vld = 1'b0;
        chk("t3_done_seen", int'(seen), 1);
        chk("t3_beats", addr_log.size(), 258);
        n = addr_log.size();
        if (n >= 4) begin
            chk("t3_addr_a", addr_log[n-4], 254);
            chk("t3_addr_b", addr_log[n-3], 255);
            chk("t3_addr_c", addr_log[n-2], 0);
            chk("t3_addr_d", addr_log[n-1], 1);
        end
        chk("t3_beats_left", exp_q.size(), 0);

        // ---- one credit, producer every 4 cycles ----
        do_reset();
        nn_q = '{3};
        alpha_cnt = 3;
        drive_fifos();
        give_credits(1);
        m_ptr = 0;
        expect_sub(3);
        for (int k = 0; k < 13; k++) begin
            cyc();
            bus.start = (k == 0);
            bus.num_subgraphs_i = 12'd1;
            bus.wh_wr_vld = (k == 5 || k == 9);
            @(negedge clk);
            chk($sformatf("t4_alpha_%0d", k), int'(bus.alpha_ff_rd_vld),
                int'(k == 2 || k == 6 || k == 10));
            chk($sformatf("t4_done_%0d", k), int'(bus.done_o), int'(k == 11));
        end
`ifdef AGGR_SCHED_PERF_EN
        chk("t4_stall", int'(bus.stall_cycles_o), 6);
`else
        chk("t4_stall", int'(bus.stall_cycles_o), 0);
`endif
        chk("t4_beats_left", exp_q.size(), 0);

        // ---- write and issue in the same cycle ----
        do_reset();
        nn_q = '{2};
        alpha_cnt = 2;
        drive_fifos();
        give_credits(2);
        m_ptr = 0;
        expect_sub(2);
        for (int k = 0; k < 6; k++) begin
            cyc();
            bus.start = (k == 0);
            bus.num_subgraphs_i = 12'd1;
            bus.wh_wr_vld = (k == 2);
            @(negedge clk);
            sp[k] = int'(bus.wh_space_o);
        end
        chk("t5_space_k2", sp[2], 254);
        chk("t5_space_k3", sp[3], 254);
        chk("t5_space_k4", sp[4], 255);

        // ---- overflow, then zero-subgraph layer clears it ----
        do_reset();
        for (int i = 0; i < 257; i++) begin
            cyc();
            bus.wh_wr_vld = 1'b1;
            if (i == 256) begin
                @(negedge clk);
                chk("t6_space_full", int'(bus.wh_space_o), 0);
                chk("t6_ovf_before", int'(bus.wh_ovf_o), 0);
            end
        end
        cyc();
        bus.wh_wr_vld = 1'b0;
        @(negedge clk);
        chk("t6_ovf_set",   int'(bus.wh_ovf_o), 1);
        chk("t6_space_hold", int'(bus.wh_space_o), 0);
        cyc();
        cyc();
        @(negedge clk);
        chk("t6_ovf_sticky", int'(bus.wh_ovf_o), 1);
        cyc();
        bus.start = 1'b1;
        bus.num_subgraphs_i = 12'd0;
        @(negedge clk);
        chk("t7_done_t0", int'(bus.done_o), 0);
        cyc();
        bus.start = 1'b0;
        @(negedge clk);
        chk("t7_done_t1", int'(bus.done_o), 1);
        chk("t7_busy_t1", int'(bus.busy_o), 1);
        chk("t7_ovf_clr", int'(bus.wh_ovf_o), 0);
        cyc();
        @(negedge clk);
        chk("t7_done_t2", int'(bus.done_o), 0);
        chk("t7_busy_t2", int'(bus.busy_o), 0);

        // ---- aggr_rdy_i low in FETCH, plus a start while busy ----
        do_reset();
        nn_q = '{2};
        alpha_cnt = 2;
        drive_fifos();
        give_credits(2);
        m_ptr = 0;
        expect_sub(2);
        for (int k = 0; k < 11; k++) begin
            cyc();
            bus.start = (k == 0 || k == 3);
            bus.num_subgraphs_i = (k == 3) ? 12'd0 : 12'd1;
            bus.aggr_rdy_i = (k == 0 || k >= 6);
            @(negedge clk);
            chk($sformatf("t8_nnrd_%0d", k),  int'(bus.nn_ff_rd_vld), int'(k == 6));
            chk($sformatf("t8_alpha_%0d", k), int'(bus.alpha_ff_rd_vld), int'(k == 7 || k == 8));
            chk($sformatf("t8_done_%0d", k),  int'(bus.done_o), int'(k == 9));
        end
        chk("t8_beats_left", exp_q.size(), 0);

        // ---- reset in the middle of RUN ----
        do_reset();
        nn_q = '{8};
        alpha_cnt = 8;
        drive_fifos();
        give_credits(8);
        m_ptr = 0;
        expect_sub(8);
        for (int k = 0; k < 7; k++) begin
            cyc();
            bus.start = (k == 0);
            bus.num_subgraphs_i = 12'd1;
            rst = (k == 4);
            @(negedge clk);
            if (k == 4) chk("t9_running", int'(bus.alpha_ff_rd_vld), 1);
            if (k == 5) begin
                chk("t9_busy",   int'(bus.busy_o), 0);
                chk("t9_ivld",   int'(bus.issue_vld_o), 0);
                chk("t9_first",  int'(bus.issue_first_o), 0);
                chk("t9_last",   int'(bus.issue_last_o), 0);
                chk("t9_done",   int'(bus.done_o), 0);
                chk("t9_alpha",  int'(bus.alpha_ff_rd_vld), 0);
                chk("t9_nnrd",   int'(bus.nn_ff_rd_vld), 0);
                chk("t9_addr",   int'(bus.wh_bram_addrb), 0);
                chk("t9_space",  int'(bus.wh_space_o), 256);
                chk("t9_ovf",    int'(bus.wh_ovf_o), 0);
                chk("t9_stall",  int'(bus.stall_cycles_o), 0);
            end
        end
        chk("t9_idle_after", int'(bus.busy_o), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
